// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console writer.
package text_console_pkg;

  // Screen geometry shared with the text buffer and VGA timing.
  localparam int unsigned DefCols  = 80;
  localparam int unsigned DefRows  = 60;
  localparam int unsigned DefCharW = 13;

  localparam logic [7:0] DefFillChar = 8'h20;

  // Control codes interpreted by the writer.
  localparam logic [7:0] ChrBs = 8'h08;
  localparam logic [7:0] ChrLf = 8'h0A;
  localparam logic [7:0] ChrFf = 8'h0C;
  localparam logic [7:0] ChrCr = 8'h0D;

  typedef enum logic {StIdle, StClear} state_e;

endpackage

// File: rtl/text_console_cursor.sv
// Column/row cursor with wrap-around; commands are mutually exclusive pulses.
module text_console_cursor import text_console_pkg::*; #(
  parameter int unsigned COLS = DefCols,
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned ColW = $clog2(COLS),
  parameter int unsigned RowW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            resetn_i,
  input  logic            home_i,
  input  logic            cr_i,
  input  logic            newline_i,
  input  logic            back_i,
  input  logic            advance_i,
  output logic [ColW-1:0] col_o,
  output logic [RowW-1:0] row_o
);

  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [RowW-1:0] row_inc;

  // Next cursor position for each command; no scrolling, rows wrap.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    row_inc = (row_q == LastRow) ? '0 : row_q + 1'b1;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (cr_i) begin
      col_d = '0;
    end else if (newline_i) begin
      col_d = '0;
      row_d = row_inc;
    end else if (back_i) begin
      if (col_q != '0) begin
        col_d = col_q - 1'b1;
      end else if (row_q != '0) begin
        col_d = LastCol;
        row_d = row_q - 1'b1;
      end
    end else if (advance_i) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to text buffer write port: cursor handling, control codes, clear sweep.
module text_console_writer import text_console_pkg::*; #(
  parameter int unsigned COLS           = DefCols,
  parameter int unsigned ROWS           = DefRows,
  parameter int unsigned CHAR_W         = DefCharW,
  parameter int unsigned ADDR_W         = $clog2(COLS * ROWS),
  parameter logic [7:0]  FILL_CHAR      = DefFillChar,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn_i,
  input  logic                     char_valid_i,
  input  logic [7:0]               char_data_i,
  output logic                     char_ready_o,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        waddr_o,
  output logic [CHAR_W-1:0]        wdata_o,
  output logic [$clog2(COLS)-1:0]  cursor_col_o,
  output logic [$clog2(ROWS)-1:0]  cursor_row_o,
  output logic                     busy_o
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [CHAR_W-1:0] FillWord = CHAR_W'(FILL_CHAR);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [CHAR_W-1:0]   wdata_q, wdata_d;

  logic [ColW-1:0]     col;
  logic [RowW-1:0]     row;
  logic [ADDR_W-1:0]   cur_addr;
  logic                xfer, at_origin;
  logic                is_ff, is_bs, is_cr, is_lf, is_print;

  assign xfer      = char_valid_i && (state_q == StIdle);
  assign cur_addr  = ADDR_W'(row) * ColsA + ADDR_W'(col);
  assign at_origin = (col == '0) && (row == '0);

  // Classify the incoming byte.
  always_comb begin
    is_ff    = 1'b0;
    is_bs    = 1'b0;
    is_cr    = 1'b0;
    is_lf    = 1'b0;
    is_print = 1'b0;
    case (char_data_i)
      ChrFf:   is_ff    = 1'b1;
      ChrBs:   is_bs    = 1'b1;
      ChrCr:   is_cr    = 1'b1;
      ChrLf:   is_lf    = 1'b1;
      default: is_print = 1'b1;
    endcase
  end

  text_console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .ColW (ColW),
    .RowW (RowW)
  ) u_cursor (
    .clk       (clk),
    .resetn_i  (resetn_i),
    .home_i    (xfer && is_ff),
    .cr_i      (xfer && is_cr),
    .newline_i (xfer && is_lf),
    .back_i    (xfer && is_bs),
    .advance_i (xfer && is_print),
    .col_o     (col),
    .row_o     (row)
  );

  // Next state and next write-port values; the FF path issues sweep address 0 itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          if (is_ff) begin
            state_d = StClear;
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = FillWord;
            cnt_d   = ADDR_W'(1);
          end else if (is_bs) begin
            // Stepping back one cell is always linear address minus one.
            if (!at_origin) begin
              we_d    = 1'b1;
              waddr_d = cur_addr - 1'b1;
              wdata_d = FillWord;
            end
          end else if (is_print) begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = CHAR_W'(char_data_i);
          end
        end
      end
      StClear: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = FillWord;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, sweep counter and registered write port.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign char_ready_o = (state_q == StIdle);
  assign busy_o       = (state_q == StClear);
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign cursor_col_o = col;
  assign cursor_row_o = row;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with hand-computed expectations.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        resetn_i = 1'b0;
  logic        char_valid_i = 1'b0;
  logic [7:0]  char_data_i = 8'h00;
  logic        char_ready_o;
  logic        we_o;
  logic [12:0] waddr_o;
  logic [12:0] wdata_o;
  logic [6:0]  cursor_col_o;
  logic [5:0]  cursor_row_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  text_console_writer dut (
    .clk          (clk),
    .resetn_i     (resetn_i),
    .char_valid_i (char_valid_i),
    .char_data_i  (char_data_i),
    .char_ready_o (char_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cursor_col_o (cursor_col_o),
    .cursor_row_o (cursor_row_o),
    .busy_o       (busy_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the transfer.
  task automatic send_byte(input logic [7:0] b);
    char_valid_i = 1'b1;
    char_data_i  = b;
    @(negedge clk);
    char_valid_i = 1'b0;
  endtask

  // Follows sweep cycles first_k..4800, where cycle k must show the write to address k-1.
  task automatic sweep_run(input string tag, input int first_k);
    int bad = 0;
    int low = 0;
    for (int k = first_k; k <= 4800; k++) begin
      @(negedge clk);
      if (!(we_o === 1'b1 && waddr_o == 13'(k - 1) && wdata_o == 13'h020)) bad++;
      if (k < 4800 && busy_o !== 1'b1) bad++;
      if (char_ready_o !== 1'b1) low++;
    end
    check_eq({tag, "_writes"}, bad, 0);
    check_eq({tag, "_ready_low"}, low, 4800 - first_k);
  endtask

  initial begin
    int found;

    // Reset state.
    @(negedge clk);
    check_eq("rst_we", we_o, 0);
    check_eq("rst_waddr", waddr_o, 0);
    check_eq("rst_wdata", wdata_o, 0);
    check_eq("rst_busy", busy_o, 1);
    check_eq("rst_ready", char_ready_o, 0);
    check_eq("rst_cursor", {cursor_col_o, cursor_row_o}, 0);
    @(negedge clk);
    resetn_i = 1'b1;

    // Power-on clear sweep.
    sweep_run("por", 1);
    @(negedge clk);
    check_eq("por_done_we", we_o, 0);
    check_eq("por_done_ready", char_ready_o, 1);
    check_eq("por_cursor", {cursor_col_o, cursor_row_o}, 0);

    // "AB" back-to-back.
    char_valid_i = 1'b1;
    char_data_i  = 8'h41;
    @(negedge clk);
    check_eq("a_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd0, 13'h041});
    check_eq("a_cursor", {cursor_col_o, cursor_row_o}, {7'd1, 6'd0});
    char_data_i = 8'h42;
    @(negedge clk);
    char_valid_i = 1'b0;
    check_eq("b_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd1, 13'h042});
    check_eq("b_cursor", {cursor_col_o, cursor_row_o}, {7'd2, 6'd0});
    @(negedge clk);
    check_eq("ab_idle_we", we_o, 0);

    // Move to (79,59), then 'Z' wraps to origin.
    for (int i = 0; i < 59; i++) send_byte(8'h0A);
    for (int i = 0; i < 79; i++) send_byte(8'h78);
    check_eq("pre_z_cursor", {cursor_col_o, cursor_row_o}, {7'd79, 6'd59});
    send_byte(8'h5A);
    check_eq("z_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd4799, 13'h05A});
    check_eq("z_cursor", {cursor_col_o, cursor_row_o}, 0);

    // Move to (5,3), LF then BS across the row boundary.
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h79);
    check_eq("pre_lf_cursor", {cursor_col_o, cursor_row_o}, {7'd5, 6'd3});
    send_byte(8'h0A);
    check_eq("lf_we", we_o, 0);
    check_eq("lf_cursor", {cursor_col_o, cursor_row_o}, {7'd0, 6'd4});
    send_byte(8'h08);
    check_eq("bs_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd319, 13'h020});
    check_eq("bs_cursor", {cursor_col_o, cursor_row_o}, {7'd79, 6'd3});

    // CR returns to column 0 without writing.
    send_byte(8'h63);
    check_eq("c_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd319, 13'h063});
    send_byte(8'h64);
    send_byte(8'h0D);
    check_eq("cr_we", we_o, 0);
    check_eq("cr_cursor", {cursor_col_o, cursor_row_o}, {7'd0, 6'd4});

    // FF with valid held and 'Q' queued behind it.
    char_valid_i = 1'b1;
    char_data_i  = 8'h0C;
    @(negedge clk);
    check_eq("ff_first", {we_o, waddr_o, wdata_o}, {1'b1, 13'd0, 13'h020});
    check_eq("ff_ready", char_ready_o, 0);
    check_eq("ff_cursor", {cursor_col_o, cursor_row_o}, 0);
    char_data_i = 8'h51;
    sweep_run("ff", 2);
    @(negedge clk);
    char_valid_i = 1'b0;
    check_eq("q_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd0, 13'h051});
    check_eq("q_cursor", {cursor_col_o, cursor_row_o}, {7'd1, 6'd0});

    // BS to origin writes, BS at origin does not.
    send_byte(8'h08);
    check_eq("bs0_write", {we_o, waddr_o, wdata_o}, {1'b1, 13'd0, 13'h020});
    check_eq("bs0_cursor", {cursor_col_o, cursor_row_o}, 0);
    send_byte(8'h08);
    check_eq("bs_origin_we", we_o, 0);
    check_eq("bs_origin_cursor", {cursor_col_o, cursor_row_o}, 0);

    // Reset in the middle of a sweep.
    send_byte(8'h41);
    send_byte(8'h0C);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (waddr_o == 13'd2000) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("mid_reach_2000", found, 1);
    resetn_i = 1'b0;
    #1;
    check_eq("mid_rst_port", {we_o, waddr_o, wdata_o}, 0);
    check_eq("mid_rst_cursor", {cursor_col_o, cursor_row_o}, 0);
    check_eq("mid_rst_busy", busy_o, 1);
    @(negedge clk);
    resetn_i = 1'b1;
    sweep_run("restart", 1);
    @(negedge clk);
    check_eq("restart_done_we", we_o, 0);
    check_eq("restart_ready", char_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end that produces the write port traffic for the 80x60 text buffer. Accepts bytes over a valid/ready handshake, keeps a cursor (column, row), interprets a small set of control codes, and issues one buffer write per printable character. Also runs a full-screen clear sweep. Sits between the APB register block (producer) and the text buffer write port (`write_enable`, `waddr_i`, `inputData`). The buffer `enable` is tied high at top level and is not driven here.

## Interface
- `COLS`, 80: characters per row.
- `ROWS`, 60: rows per screen.
- `CHAR_W`, 13: buffer entry width; must equal the text buffer data width.
- `ADDR_W`, $clog2(COLS*ROWS): buffer address width.
- `FILL_CHAR`, 8'h20: value written by clear and backspace.
- `CLEAR_ON_RESET`, 1: run a clear sweep after reset release.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `resetn_i`  in  1  asynchronous, active-low reset.
- `char_valid_i`  in  1  producer has a byte.
- `char_data_i`  in  8  byte, stable while valid.
- `char_ready_o`  out  1  block accepts this cycle.
- `we_o`  out  1  to buffer `write_enable`.
- `waddr_o`  out  ADDR_W  to buffer `waddr_i`.
- `wdata_o`  out  CHAR_W  to buffer `inputData`, byte zero-extended.
- `cursor_col_o`  out  $clog2(COLS)  current column.
- `cursor_row_o`  out  $clog2(ROWS)  current row.
- `busy_o`  out  1  clear sweep in progress.

## Operation
- States: IDLE, CLEAR. `char_ready_o = (state == IDLE)`; `busy_o = (state == CLEAR)`.
- Transfer occurs on an edge with `char_valid_i && char_ready_o`. Valid must not depend on ready.
- Byte decode on transfer:
  - 0x0D (CR): col←0. No write.
  - 0x0A (LF): col←0, row←row+1 with ROWS-1→0 wrap. No write.
  - 0x08 (BS): if col>0, col←col-1. Else if row>0, col←COLS-1 and row←row-1. Write FILL_CHAR at the new position. At (0,0): no-op, no write.
  - 0x0C (FF): enter CLEAR with sweep counter 0. The cursor goes to (0,0) immediately.
  - Any other byte: write it at the current cursor position, then advance col. Advancing past col COLS-1 sets col←0 and row←row+1, with row wrap ROWS-1→0. There is no scrolling.
- Address is `row*COLS + col`, computed at ADDR_W width. It never exceeds COLS*ROWS-1.
- CLEAR: each cycle writes FILL_CHAR at the counter value, then increments the counter. After issuing address COLS*ROWS-1, return to IDLE.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Counter 0, cursor (0,0).
  - `we_o`=0, `waddr_o`=0, `wdata_o`=0.
- Reset asserted mid-sweep aborts the sweep. On release the sweep restarts from address 0 (CLEAR_ON_RESET=1), or the block goes to IDLE (=0).

## Timing
- `we_o`, `waddr_o`, `wdata_o` are registered. A transfer at edge N produces the write in cycle N+1, so the buffer captures it at edge N+1.
- `we_o` is high for exactly one cycle per writing transfer.
- Cursor outputs update at the transfer edge N.
- Throughput is one byte per cycle in IDLE. Back-to-back transfers produce back-to-back writes.
- FF accepted at edge N:
  - `we_o` is high for cycles N+1 .. N+COLS*ROWS (4800 consecutive writes, addresses 0..4799).
  - `char_ready_o` is low during cycles N+1 .. N+4799 and high again in cycle N+4800.
- Reset release with CLEAR_ON_RESET: the first sweep write appears in the cycle after the first edge following release.

## Structure
- Package `text_console_pkg`:
  - Control codes CR/LF/BS/FF.
  - Default FILL_CHAR.
  - State enum {IDLE, CLEAR}.
  - COLS/ROWS defaults shared with the text buffer and VGA timing.
- Optional sub-module `text_console_cursor`: col/row counters with advance, newline, back and home commands, plus wrap logic.
- Everything else lives in one module.

## Test plan
- Reset with CLEAR_ON_RESET=1 → 4800 contiguous writes of 0x20 at addresses 0..4799, `busy_o` high throughout, then `char_ready_o`=1 and cursor (0,0).
- Send "AB" back-to-back from (0,0) → writes (0,0x41) and (1,0x42) on consecutive cycles; cursor (2,0).
- Cursor at (79,59), send 'Z' → write addr 4799 data 0x5A; cursor wraps to (0,0).
- Cursor (5,3), send LF → no write, cursor (0,4). Then BS → write 0x20 at addr 319, cursor (79,3). BS at (0,0) → no write.
- Send FF with valid held high and next byte 'Q' → ready low for 4799 cycles, 4800 fill writes, then 'Q' written at addr 0.
- Assert `resetn_i` at sweep address 2000 → outputs zero immediately; after release the sweep restarts at address 0.
